// File: rtl/uart_tx_stream.sv
// UART transmitter fed from a valid/ready stream, with a one-word holding register
// so that consecutive frames go out back-to-back with no idle gap.
module uart_tx_stream #(
  parameter int unsigned CLK_FREQ  = 48_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_VALID,
  output logic                 TX_READY,
  output logic                 UART_TX,
  output logic                 TX_BUSY
);

  localparam int unsigned CyclesPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW         = (CyclesPerBit < 2) ? 1 : $clog2(CyclesPerBit);
  localparam int unsigned BitW         = 4;

  localparam logic [CntW-1:0] CntLast  = CntW'(CyclesPerBit - 1);
  localparam logic [BitW-1:0] DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
    $error("uart_tx_stream: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_err_parity
    $error("uart_tx_stream: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop_bits
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (CyclesPerBit < 2) begin : g_err_cycles
    $error("uart_tx_stream: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic accept;
  logic load;
  logic bit_end;

  assign accept  = TX_VALID && !hold_full_q;
  assign bit_end = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    tx_d        = tx_q;
    load        = 1'b0;

    if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = TX_DATA;
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        load = hold_full_q;
      end

      StStart: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = StPar;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StPar: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StStop;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == StopLast) begin
            // A waiting word starts on the very next edge, giving zero idle cycles.
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // load only fires when hold_full_q is set, so it never collides with accept.
    if (load) begin
      state_d     = StStart;
      cnt_d       = '0;
      bit_d       = '0;
      shift_d     = hold_q;
      par_d       = (PARITY == 2) ? (^hold_q) : ~(^hold_q);
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
    end

    // Old hold_full keeps busy aligned with the start bit rather than the accept edge.
    busy_d = (state_d != StIdle) || hold_full_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign TX_READY = !hold_full_q;
  assign UART_TX  = tx_q;
  assign TX_BUSY  = busy_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: four frame formats driven from one stream, compared cycle by
// cycle against a frame model built from the line-format rules.
module tb_uart_tx_stream;

  localparam int Cpb = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic [1:0] sel;
  logic [3:0] valid_v;
  wire  [3:0] rdy_v;
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  logic       rdy_m, tx_m, busy_m;

  int checks = 0;
  int errors = 0;

  int cfg_db[4]   = '{8, 8, 8, 7};
  int cfg_par[4]  = '{0, 2, 1, 0};
  int cfg_stop[4] = '{1, 1, 1, 2};

  bit         obs_tx[$], obs_busy[$], obs_rdy[$];
  bit         exp_tx[$], exp_busy[$];
  logic [8:0] words[$];
  bit         acc_flag;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) valid_v[k] = tx_valid && (sel == 2'(k));
    rdy_m  = rdy_v[sel];
    tx_m   = tx_v[sel];
    busy_m = busy_v[sel];
  end

  uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1)) u_8n1 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data[7:0]), .TX_VALID(valid_v[0]),
    .TX_READY(rdy_v[0]), .UART_TX(tx_v[0]), .TX_BUSY(busy_v[0]));

  uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1)) u_8e1 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data[7:0]), .TX_VALID(valid_v[1]),
    .TX_READY(rdy_v[1]), .UART_TX(tx_v[1]), .TX_BUSY(busy_v[1]));

  uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1)) u_8o1 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data[7:0]), .TX_VALID(valid_v[2]),
    .TX_READY(rdy_v[2]), .UART_TX(tx_v[2]), .TX_BUSY(busy_v[2]));

  uart_tx_stream #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2)) u_7n2 (
    .CLK(clk), .RST(rst), .TX_DATA(tx_data[6:0]), .TX_VALID(valid_v[3]),
    .TX_READY(rdy_v[3]), .UART_TX(tx_v[3]), .TX_BUSY(busy_v[3]));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int s);
    return 1 + cfg_db[s] + ((cfg_par[s] != 0) ? 1 : 0) + cfg_stop[s];
  endfunction

  // Appends one frame of line bits, each held for a full bit time.
  task automatic push_frame(input int s, input logic [8:0] w);
    bit bits[$];
    int ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[s]; i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (cfg_par[s] == 2) bits.push_back(bit'(ones % 2));
    else if (cfg_par[s] == 1) bits.push_back(bit'(1 - ones % 2));
    for (int i = 0; i < cfg_stop[s]; i++) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int c = 0; c < Cpb; c++) begin
        exp_tx.push_back(bits[j]);
        exp_busy.push_back(1'b1);
      end
    end
  endtask

  // Clears history; the first two samples precede the start bit of the first frame.
  task automatic start_test(input int s, input bit load_first);
    sel = 2'(s);
    obs_tx.delete(); obs_busy.delete(); obs_rdy.delete();
    exp_tx.delete(); exp_busy.delete(); words.delete();
    acc_flag = load_first;
    for (int i = 0; i < 2; i++) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic add_word(input int s, input logic [8:0] w);
    words.push_back(w);
    push_frame(s, w);
  endtask

  // Samples on the falling edge; a new word is presented only after the last one was taken.
  task automatic run(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_tx.push_back(tx_m);
      obs_busy.push_back(busy_m);
      obs_rdy.push_back(rdy_m);
      if (acc_flag) begin
        if (words.size() > 0) begin
          tx_data  = words.pop_front();
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (toggle && !tx_valid) tx_data = 9'($urandom);
      acc_flag = tx_valid && rdy_m;
    end
    while (exp_tx.size() < obs_tx.size()) begin
      exp_tx.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
  endtask

  task automatic compare(input string tag, input int s, input int nframes);
    int etx = 0, ebusy = 0, erdy = 0, busy_cnt = 0;
    int l = frame_len(s) * Cpb;
    foreach (obs_tx[i]) begin
      if (obs_tx[i] !== exp_tx[i]) etx++;
      if (obs_busy[i] !== exp_busy[i]) ebusy++;
      busy_cnt += int'(obs_busy[i]);
    end
    for (int k = 0; k < nframes; k++) begin
      if (obs_rdy[2 + k * l] !== 1'b1 || obs_rdy[1 + k * l] !== 1'b0) erdy++;
    end
    check({tag, "_tx_bad_cycles"}, etx, 0);
    check({tag, "_busy_bad_cycles"}, ebusy, 0);
    check({tag, "_ready_at_start_bad"}, erdy, 0);
    check({tag, "_busy_cycles"}, busy_cnt, nframes * l);
  endtask

  task automatic send_random(input string tag, input int s, input int n);
    start_test(s, 1'b1);
    for (int i = 0; i < n; i++) add_word(s, 9'($urandom));
    run(2 + n * frame_len(s) * Cpb + 8, 1'b0);
    compare(tag, s, n);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    sel      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("reset_tx_%0d", s), int'(tx_v[s]), 1);
      check($sformatf("reset_ready_%0d", s), int'(rdy_v[s]), 1);
      check($sformatf("reset_busy_%0d", s), int'(busy_v[s]), 0);
    end
    rst = 1'b0;

    // 8N1 single frame of 0x61.
    start_test(0, 1'b1);
    add_word(0, 9'h061);
    run(112, 1'b0);
    compare("t1_8n1", 0, 1);
    cnt = 0;
    foreach (obs_rdy[i]) cnt += int'(!obs_rdy[i]);
    check("t1_ready_low_cycles", cnt, 1);
    check("t1_bit6_mid", int'(obs_tx[2 + 7 * Cpb + 5]), 1);

    // Three words streamed with valid held high.
    start_test(0, 1'b1);
    add_word(0, 9'h055);
    add_word(0, 9'h0AA);
    add_word(0, 9'h00F);
    run(2 + 300 + 8, 1'b0);
    compare("t2_b2b", 0, 3);
    send_random("t2_rand", 0, 3);

    // Parity: even gives 1 for 0x61, odd gives 0.
    start_test(1, 1'b1);
    add_word(1, 9'h061);
    run(2 + 110 + 8, 1'b0);
    compare("t3_8e1", 1, 1);
    check("t3_even_parity_bit", int'(obs_tx[2 + 9 * Cpb + 5]), 1);
    start_test(2, 1'b1);
    add_word(2, 9'h061);
    run(2 + 110 + 8, 1'b0);
    compare("t3_8o1", 2, 1);
    check("t3_odd_parity_bit", int'(obs_tx[2 + 9 * Cpb + 5]), 0);
    send_random("t3_8e1_rand", 1, 2);
    send_random("t3_8o1_rand", 2, 2);

    // 7N2 with 0x7F, then random back-to-back words.
    start_test(3, 1'b1);
    add_word(3, 9'h07F);
    run(2 + 100 + 8, 1'b0);
    compare("t4_7n2", 3, 1);
    cnt = 0;
    for (int i = 2 + Cpb; i < 2 + 100; i++) cnt += int'(obs_tx[i]);
    check("t4_high_cycles_after_start", cnt, 90);
    send_random("t4_rand", 3, 2);

    // Reset during cycle 35 of a frame with a second word held.
    start_test(0, 1'b1);
    add_word(0, 9'h061);
    add_word(0, 9'($urandom));
    run(37, 1'b0);
    check("t5_word_held_ready", int'(rdy_m), 0);
    rst      = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    check("t5_reset_tx", int'(tx_m), 1);
    check("t5_reset_ready", int'(rdy_m), 1);
    check("t5_reset_busy", int'(busy_m), 0);
    rst = 1'b0;
    start_test(0, 1'b0);
    run(300, 1'b0);
    compare("t5_after_reset_quiet", 0, 0);
    send_random("t5_resume", 0, 1);

    // Long idle with TX_DATA toggling and TX_VALID low.
    start_test(0, 1'b0);
    run(500, 1'b1);
    cnt = 0;
    foreach (obs_tx[i]) cnt += int'(obs_tx[i] !== 1'b1 || obs_busy[i] !== 1'b0 || obs_rdy[i] !== 1'b1);
    check("t6_idle_bad_cycles", cnt, 0);
    check("t6_all_busy", int'(busy_v), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
